// File: rtl/work_link.sv
// Host bridge: frames 80-byte work packets into a 640-bit word and serialises found nonces as 5-byte response frames.
// RX is a fixed pipeline with no backpressure. TX holds one pending nonce while another frame is sent, and it stalls on tx_ready.
module work_link #(
  parameter logic [7:0] CMD_WORK       = 8'h01,
  parameter logic [7:0] RSP_NONCE      = 8'h02,
  parameter int         TIMEOUT_CYCLES = 1000000,
  parameter int         TO_W           = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         rx_valid,
  input  logic [7:0]   rx_data,
  output logic         tx_valid,
  output logic [7:0]   tx_data,
  input  logic         tx_ready,
  output logic         new_work,
  output logic [639:0] work_data,
  input  logic         new_result,
  input  logic [31:0]  result_data,
  output logic         frame_err,
  output logic         res_overflow
);

  localparam logic [TO_W-1:0] TO_LIMIT = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

  typedef enum logic {R_IDLE, R_PAYLOAD} rx_state_t;
  typedef enum logic {T_IDLE, T_SEND} tx_state_t;

  rx_state_t        rx_state, rx_next;
  logic [639:0]     sr;
  logic [6:0]       byte_cnt;
  logic [TO_W-1:0]  to_cnt;
  logic             rx_accept, rx_last, rx_timeout, rx_bad;

  tx_state_t        tx_state, tx_next;
  logic [2:0]       tx_idx;
  logic [31:0]      tx_nonce;
  logic             pend_valid;
  logic [31:0]      pend_nonce;
  logic             tx_load, tx_xfer;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_state <= R_IDLE;
      tx_state <= T_IDLE;
    end else begin
      rx_state <= rx_next;
      tx_state <= tx_next;
    end
  end

  // The timeout fires on the TIMEOUT_CYCLES-th consecutive idle cycle inside a payload.
  always_comb begin
    rx_next    = rx_state;
    rx_accept  = 1'b0;
    rx_last    = 1'b0;
    rx_timeout = 1'b0;
    rx_bad     = 1'b0;
    case (rx_state)
      R_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WORK) rx_next = R_PAYLOAD;
          else                     rx_bad  = 1'b1;
        end
      end
      R_PAYLOAD: begin
        if (rx_valid) begin
          rx_accept = 1'b1;
          if (byte_cnt == 7'd79) begin
            rx_last = 1'b1;
            rx_next = R_IDLE;
          end
        end else if (to_cnt == TO_LIMIT) begin
          rx_timeout = 1'b1;
          rx_next    = R_IDLE;
        end
      end
      default: rx_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sr        <= '0;
      byte_cnt  <= '0;
      to_cnt    <= '0;
      work_data <= '0;
      new_work  <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      new_work  <= rx_last;
      frame_err <= rx_bad | rx_timeout;
      if (rx_state == R_IDLE) begin
        byte_cnt <= '0;
        to_cnt   <= '0;
      end else if (rx_accept) begin
        sr       <= {sr[631:0], rx_data};
        byte_cnt <= byte_cnt + 7'd1;
        to_cnt   <= '0;
      end else begin
        to_cnt   <= to_cnt + TO_ONE;
      end
      if (rx_last) work_data <= {sr[631:0], rx_data};
    end
  end

  always_comb begin
    tx_next  = tx_state;
    tx_valid = 1'b0;
    tx_data  = 8'h00;
    tx_load  = 1'b0;
    tx_xfer  = 1'b0;
    case (tx_state)
      T_IDLE: begin
        if (pend_valid) begin
          tx_load = 1'b1;
          tx_next = T_SEND;
        end
      end
      T_SEND: begin
        tx_valid = 1'b1;
        tx_xfer  = tx_ready;
        case (tx_idx)
          3'd0:    tx_data = RSP_NONCE;
          3'd1:    tx_data = tx_nonce[7:0];
          3'd2:    tx_data = tx_nonce[15:8];
          3'd3:    tx_data = tx_nonce[23:16];
          default: tx_data = tx_nonce[31:24];
        endcase
        if (tx_ready && tx_idx == 3'd4) tx_next = T_IDLE;
      end
      default: tx_next = T_IDLE;
    endcase
  end

  // A slot freed by tx_load in the same cycle may take the incoming nonce.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_valid   <= 1'b0;
      pend_nonce   <= '0;
      res_overflow <= 1'b0;
      tx_idx       <= '0;
      tx_nonce     <= '0;
    end else begin
      if (new_result && (!pend_valid || tx_load)) begin
        pend_valid <= 1'b1;
        pend_nonce <= result_data;
      end else if (tx_load) begin
        pend_valid <= 1'b0;
      end
      if (new_result && pend_valid && !tx_load) res_overflow <= 1'b1;
      if (tx_load) begin
        tx_nonce <= pend_nonce;
        tx_idx   <= '0;
      end else if (tx_xfer) begin
        tx_idx   <= (tx_idx == 3'd4) ? 3'd0 : tx_idx + 3'd1;
      end
    end
  end

endmodule

// File: tb/tb_work_link.sv
// Bench for work_link: stimulus tables plus a scoreboard of expected work words and tx bytes, checked at negedge.
module tb_work_link;
  logic         clk = 1'b0;
  logic         rst;
  logic         rx_valid, tx_valid, tx_ready, new_work, new_result, frame_err, res_overflow;
  logic [7:0]   rx_data, tx_data;
  logic [639:0] work_data;
  logic [31:0]  result_data;

  always #5 clk = ~clk;

  work_link #(.CMD_WORK(8'h01), .RSP_NONCE(8'h02), .TIMEOUT_CYCLES(64), .TO_W(8)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .new_work(new_work), .work_data(work_data),
    .new_result(new_result), .result_data(result_data),
    .frame_err(frame_err), .res_overflow(res_overflow)
  );

  int tests = 0, fails = 0;
  int nw_count = 0, tx_count = 0;
  logic [639:0] work_q[$];
  logic [7:0]   tx_q[$];
  logic         hold_vld = 1'b0;
  logic [7:0]   hold_dat = 8'h00;

  typedef struct { logic [31:0] nonce; bit rnd; logic [4:0][7:0] exp; } tx_vec_t;
  typedef struct { logic [7:0] b; logic exp_err; } rx_vec_t;

  task automatic chk(input string nm, input logic [639:0] act, input logic [639:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h", nm, act, exp);
    end
  endtask

  task automatic unexpected(input string nm);
    tests++;
    fails++;
    $display("FAIL %s: got event, required none", nm);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (new_work) begin
        nw_count++;
        if (work_q.size() == 0) unexpected("new_work_unexpected");
        else chk("work_data", work_data, work_q.pop_front());
      end
      if (tx_valid && tx_ready) begin
        tx_count++;
        if (tx_q.size() == 0) unexpected("tx_byte_unexpected");
        else chk("tx_byte", tx_data, tx_q.pop_front());
      end
      if (hold_vld && tx_valid) chk("tx_hold_stable", tx_data, hold_dat);
      hold_vld = tx_valid && !tx_ready;
      hold_dat = tx_data;
    end else begin
      hold_vld = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  function automatic logic [639:0] frame_val(input logic [7:0] base);
    logic [639:0] v;
    v = '0;
    for (int i = 0; i < 80; i++) v[639-8*i -: 8] = 8'(base + i);
    return v;
  endfunction

  task automatic send_frame(input logic [7:0] base);
    work_q.push_back(frame_val(base));
    send_byte(8'h01);
    for (int i = 0; i < 80; i++) send_byte(8'(base + i));
  endtask

  task automatic post(input logic [31:0] n, input bit push);
    if (push) begin
      tx_q.push_back(8'h02);
      tx_q.push_back(n[7:0]);
      tx_q.push_back(n[15:8]);
      tx_q.push_back(n[23:16]);
      tx_q.push_back(n[31:24]);
    end
    new_result  = 1'b1;
    result_data = n;
    tick();
    new_result  = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_new_work"}, new_work, 1'b0);
    chk({tag, "_frame_err"}, frame_err, 1'b0);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, 8'h00);
    chk({tag, "_res_overflow"}, res_overflow, 1'b0);
    chk({tag, "_work_data"}, work_data, 640'h0);
  endtask

  initial begin
    tx_vec_t tv[4];
    rx_vec_t rv[4];
    int n, start, nw0, chg;

    tv[0] = '{32'hDEADBEEF, 1'b0, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h02}};
    tv[1] = '{32'hDEADBEEF, 1'b1, {8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h02}};
    tv[2] = '{32'h01234567, 1'b0, {8'h01, 8'h23, 8'h45, 8'h67, 8'h02}};
    tv[3] = '{32'h80000001, 1'b1, {8'h80, 8'h00, 8'h00, 8'h01, 8'h02}};
    rv[0] = '{8'h55, 1'b1};
    rv[1] = '{8'h00, 1'b1};
    rv[2] = '{8'hFF, 1'b1};
    rv[3] = '{8'h02, 1'b1};

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; tx_ready = 1'b1;
    new_result = 1'b0; result_data = 32'h0;
    #12;
    check_all_zero("reset");
    rst = 1'b0;
    tick();

    // Full frame; 0x01 at payload index 1 must be treated as data.
    send_frame(8'h00);
    chk("new_work_pulse", new_work, 1'b1);
    chk("work_first_byte", work_data[639:632], 8'h00);
    chk("work_last_byte", work_data[7:0], 8'h4F);
    tick();
    chk("new_work_single", new_work, 1'b0);
    chg = 0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (work_data !== frame_val(8'h00)) chg++;
    end
    chk("work_stable_changes", chg, 0);
    chk("new_work_count", nw_count, 1);

    nw0 = nw_count;
    for (int i = 0; i < 4; i++) begin
      send_byte(rv[i].b);
      chk("bad_cmd_err", frame_err, rv[i].exp_err);
      tick();
      chk("bad_cmd_err_clear", frame_err, 1'b0);
    end
    chk("bad_cmd_no_work", nw_count, nw0);

    send_byte(8'h01);
    for (int i = 0; i < 10; i++) send_byte(8'(8'h30 + i));
    n = 0;
    for (int i = 1; i <= 200; i++) begin
      tick();
      if (frame_err) begin
        n = i;
        break;
      end
    end
    chk("timeout_idle_cycles", n, 64);
    tick();
    chk("timeout_work_kept", work_data, frame_val(8'h00));
    chk("timeout_no_work", nw_count, nw0);

    send_frame(8'hA0);
    chk("after_timeout_new_work", new_work, 1'b1);
    tick();
    chk("after_timeout_count", nw_count, nw0 + 1);

    for (int v = 0; v < 4; v++) begin
      for (int k = 0; k < 5; k++) tx_q.push_back(tv[v].exp[k]);
      tx_ready = tv[v].rnd ? 1'b0 : 1'b1;
      start = tx_count;
      post(tv[v].nonce, 1'b0);
      n = 301;
      for (int i = 1; i <= 300; i++) begin
        tick();
        if (tx_count == start + 5) begin
          n = i;
          break;
        end
        if (tv[v].rnd) tx_ready = 1'($urandom_range(0, 1));
      end
      if (!tv[v].rnd) chk("tx_latency", n, 6);
      else chk("tx_done_in_budget", n <= 300, 1'b1);
      chk("tx_valid_after_frame", tx_valid, 1'b0);
      chk("tx_queue_drained", tx_q.size(), 0);
      tick();
    end

    tx_ready = 1'b0;
    start = tx_count;
    post(32'h11111111, 1'b1);
    post(32'h22222222, 1'b1);
    chk("overflow_not_yet", res_overflow, 1'b0);
    post(32'h33333333, 1'b0);
    chk("overflow_set", res_overflow, 1'b1);
    tick();
    tx_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (tx_count == start + 10) break;
    end
    for (int i = 0; i < 20; i++) tick();
    chk("overflow_tx_bytes", tx_count, start + 10);
    chk("overflow_queue_drained", tx_q.size(), 0);
    chk("overflow_sticky", res_overflow, 1'b1);

    nw0 = nw_count;
    send_byte(8'h01);
    for (int i = 0; i < 40; i++) send_byte(8'(i));
    #2 rst = 1'b1;
    #1 check_all_zero("rx_async_rst");
    #3 rst = 1'b0;
    for (int i = 40; i < 80; i++) send_byte(8'(i));
    for (int i = 0; i < 10; i++) tick();
    chk("rx_rst_no_work", nw_count, nw0);

    tx_ready = 1'b1;
    start = tx_count;
    post(32'hCAFEF00D, 1'b1);
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx_count == start + 2) break;
    end
    chk("tx_rst_at_idx2", tx_count, start + 2);
    #2 rst = 1'b1;
    #1 check_all_zero("tx_async_rst");
    tx_q.delete();
    #3 rst = 1'b0;
    for (int i = 0; i < 30; i++) tick();
    chk("tx_rst_no_stray", tx_count, start + 2);
    chk("tx_rst_no_work", nw_count, nw0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
